kyogenrv_avm_arbiter: RTL and testbench

- Shares one Avalon-MM master port between the KyogenRV instruction-fetch requester (read-only) and data requester (read/write).
- Sits between the CPU wrapper's imem/dmem interfaces and a single system interconnect port.
- Holds each command stable through `waitrequest` and supports pipelined reads.
- Tracks outstanding read IDs so `readdatavalid` beats return to the requester that issued them.

---
 rtl/kyogenrv_avm_pkg.sv | 19 +
 rtl/kyogenrv_avm_arbiter_if.sv | 52 +++++
 rtl/kyogenrv_id_fifo.sv | 70 +++++++
 rtl/kyogenrv_avm_arbiter.sv | 133 +++++++++++++
 tb/tb_kyogenrv_avm_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kyogenrv_avm_pkg.sv
// Shared types and default widths for the KyogenRV Avalon-MM arbiter.
package kyogenrv_avm_pkg;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    localparam int unsigned DEF_ADDR_W          = 32;
    localparam int unsigned DEF_DATA_W          = 32;
    localparam int unsigned DEF_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/kyogenrv_avm_arbiter_if.sv
// Bus bundle for the arbiter: imem and dmem requester ports plus the shared master port.
// Modport master is the arbiter's view; modport slave is the CPU/interconnect side.
interface kyogenrv_avm_arbiter_if
    import kyogenrv_avm_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);

    logic                  i_read;
    logic [ADDR_W-1:0]     i_address;
    logic                  i_waitrequest;
    logic [DATA_W-1:0]     i_readdata;
    logic                  i_readdatavalid;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_W-1:0]     d_address;
    logic [DATA_W-1:0]     d_writedata;
    logic [DATA_W/8-1:0]   d_byteenable;
    logic                  d_waitrequest;
    logic [DATA_W-1:0]     d_readdata;
    logic                  d_readdatavalid;

    logic [ADDR_W-1:0]     m_address;
    logic                  m_read;
    logic                  m_write;
    logic [DATA_W-1:0]     m_writedata;
    logic [DATA_W/8-1:0]   m_byteenable;
    logic                  m_waitrequest;
    logic [DATA_W-1:0]     m_readdata;
    logic                  m_readdatavalid;

    modport master (
        input  i_read, i_address,
        output i_waitrequest, i_readdata, i_readdatavalid,
        input  d_read, d_write, d_address, d_writedata, d_byteenable,
        output d_waitrequest, d_readdata, d_readdatavalid,
        output m_address, m_read, m_write, m_writedata, m_byteenable,
        input  m_waitrequest, m_readdata, m_readdatavalid
    );

    modport slave (
        output i_read, i_address,
        input  i_waitrequest, i_readdata, i_readdatavalid,
        output d_read, d_write, d_address, d_writedata, d_byteenable,
        input  d_waitrequest, d_readdata, d_readdatavalid,
        input  m_address, m_read, m_write, m_writedata, m_byteenable,
        output m_waitrequest, m_readdata, m_readdatavalid
    );

endinterface

// File: rtl/kyogenrv_id_fifo.sv
// Small synchronous FIFO of requester IDs recording the issue order of outstanding reads.
module kyogenrv_id_fifo
    import kyogenrv_avm_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_MAX_OUTSTANDING,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  req_id_t          push_id,
    input  logic             pop,
    output req_id_t          head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    req_id_t          mem_q [DEPTH];
    req_id_t          mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Pointers wrap naturally because DEPTH is a power of two.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/kyogenrv_avm_arbiter.sv
// Shares one Avalon-MM master between the KyogenRV imem (read-only) and dmem requesters.
// Define KRV_AVM_ARB_RR_EN for round-robin arbitration; default is fixed dmem-over-imem.
module kyogenrv_avm_arbiter
    import kyogenrv_avm_pkg::*;
#(
    parameter int unsigned ADDR_W          = DEF_ADDR_W,
    parameter int unsigned DATA_W          = DEF_DATA_W,
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                   clock,
    input  logic                   reset,
    kyogenrv_avm_arbiter_if.master bus,
    output logic                   err_unexpected_rdv
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_t       state_q, state_d;
    logic             err_q, err_d;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    req_id_t          fifo_push_id, fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             unused_fifo_count;
    logic             d_is_write, d_elig, i_elig, prefer_d, rsp_valid;

    assign unused_fifo_count = ^fifo_count;

    kyogenrv_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (fifo_push),
        .push_id (fifo_push_id),
        .pop     (fifo_pop),
        .head    (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A simultaneous read+write from dmem is treated as a write.
    assign d_is_write = bus.d_write;
    assign d_elig     = d_is_write | (bus.d_read & ~fifo_full);
    assign i_elig     = bus.i_read & ~fifo_full;

`ifdef KRV_AVM_ARB_RR_EN
    req_id_t last_grant_q, last_grant_d;

    assign prefer_d = (last_grant_q == REQ_I);

    always_ff @(posedge clock) begin
        if (reset) last_grant_q <= REQ_I;
        else       last_grant_q <= last_grant_d;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE) begin
            if (state_d == GNT_D)      last_grant_d = REQ_D;
            else if (state_d == GNT_I) last_grant_d = REQ_I;
        end
    end
`else
    assign prefer_d = 1'b1;
`endif

    always_comb begin
        state_d           = state_q;
        bus.m_read        = 1'b0;
        bus.m_write       = 1'b0;
        bus.m_address     = {ADDR_W{1'b0}};
        bus.m_writedata   = {DATA_W{1'b0}};
        bus.m_byteenable  = {(DATA_W/8){1'b0}};
        bus.i_waitrequest = bus.i_read;
        bus.d_waitrequest = bus.d_read | bus.d_write;
        fifo_push         = 1'b0;
        fifo_push_id      = REQ_I;
        case (state_q)
            IDLE: begin
                if (d_elig && (!i_elig || prefer_d)) state_d = GNT_D;
                else if (i_elig)                     state_d = GNT_I;
            end
            GNT_I: begin
                bus.m_read       = 1'b1;
                bus.m_address    = bus.i_address;
                bus.m_byteenable = {(DATA_W/8){1'b1}};
                if (!bus.m_waitrequest) begin
                    bus.i_waitrequest = 1'b0;
                    fifo_push         = 1'b1;
                    fifo_push_id      = REQ_I;
                    state_d           = IDLE;
                end
            end
            GNT_D: begin
                bus.m_write      = d_is_write;
                bus.m_read       = bus.d_read & ~d_is_write;
                bus.m_address    = bus.d_address;
                bus.m_writedata  = bus.d_writedata;
                bus.m_byteenable = bus.d_byteenable;
                if (!bus.m_waitrequest) begin
                    bus.d_waitrequest = 1'b0;
                    fifo_push         = bus.d_read & ~d_is_write;
                    fifo_push_id      = REQ_D;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Responses come back in issue order; the FIFO head names their owner.
    assign rsp_valid           = bus.m_readdatavalid & ~fifo_empty;
    assign fifo_pop            = rsp_valid;
    assign bus.i_readdata      = bus.m_readdata;
    assign bus.d_readdata      = bus.m_readdata;
    assign bus.i_readdatavalid = rsp_valid & (fifo_head == REQ_I);
    assign bus.d_readdatavalid = rsp_valid & (fifo_head == REQ_D);

    assign err_d              = err_q | (bus.m_readdatavalid & fifo_empty);
    assign err_unexpected_rdv = err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_kyogenrv_avm_arbiter.sv
// Directed self-checking bench for kyogenrv_avm_arbiter.
module tb_kyogenrv_avm_arbiter;

    logic clock;
    logic reset;
    logic err;
    int   nchk;
    int   nfail;

    kyogenrv_avm_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    kyogenrv_avm_arbiter #(
        .ADDR_W          (32),
        .DATA_W          (32),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .bus                (bus),
        .err_unexpected_rdv (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        bus.i_read = 1'b1;
        #1;
        nchk++; if (bus.m_read !== 1'b0) begin nfail++; $display("FAIL rst_m_read: got %b want 0", bus.m_read); end
        nchk++; if (bus.m_write !== 1'b0) begin nfail++; $display("FAIL rst_m_write: got %b want 0", bus.m_write); end
        nchk++; if (bus.m_address !== 32'h0) begin nfail++; $display("FAIL rst_m_address: got %h want 0", bus.m_address); end
        nchk++; if (bus.i_waitrequest !== 1'b1) begin nfail++; $display("FAIL rst_i_wr_req: got %b want 1", bus.i_waitrequest); end
        nchk++; if (bus.d_waitrequest !== 1'b0) begin nfail++; $display("FAIL rst_d_wr_idle: got %b want 0", bus.d_waitrequest); end
        nchk++; if (bus.i_readdatavalid !== 1'b0) begin nfail++; $display("FAIL rst_i_rdv: got %b want 0", bus.i_readdatavalid); end
        nchk++; if (err !== 1'b0) begin nfail++; $display("FAIL rst_err: got %b want 0", err); end
        tick();
        nchk++; if (bus.m_read !== 1'b0) begin nfail++; $display("FAIL rst_held_m_read: got %b want 0", bus.m_read); end
        bus.i_read = 1'b0;
        reset      = 1'b0;
        #1;
        nchk++; if (bus.i_waitrequest !== 1'b0) begin nfail++; $display("FAIL rst_i_wr_noreq: got %b want 0", bus.i_waitrequest); end
    endtask

    task automatic test_single_read();
        tick();
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_0100;
        #1;
        nchk++; if (bus.m_read !== 1'b0) begin nfail++; $display("FAIL sr_c1_m_read: got %b want 0", bus.m_read); end
        nchk++; if (bus.i_waitrequest !== 1'b1) begin nfail++; $display("FAIL sr_c1_i_wr: got %b want 1", bus.i_waitrequest); end
        tick();
        #1;
        nchk++; if (bus.m_read !== 1'b1) begin nfail++; $display("FAIL sr_c2_m_read: got %b want 1", bus.m_read); end
        nchk++; if (bus.m_address !== 32'h100) begin nfail++; $display("FAIL sr_c2_addr: got %h want 00000100", bus.m_address); end
        nchk++; if (bus.m_byteenable !== 4'hF) begin nfail++; $display("FAIL sr_c2_be: got %h want f", bus.m_byteenable); end
        nchk++; if (bus.m_write !== 1'b0) begin nfail++; $display("FAIL sr_c2_m_write: got %b want 0", bus.m_write); end
        nchk++; if (bus.i_waitrequest !== 1'b0) begin nfail++; $display("FAIL sr_c2_i_wr: got %b want 0", bus.i_waitrequest); end
        tick();
        bus.i_read = 1'b0;
        #1;
        nchk++; if (bus.m_read !== 1'b0) begin nfail++; $display("FAIL sr_c3_m_read: got %b want 0", bus.m_read); end
        tick();
        tick();
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata      = 32'hDEAD_BEEF;
        #1;
        nchk++; if (bus.i_readdatavalid !== 1'b1) begin nfail++; $display("FAIL sr_i_rdv: got %b want 1", bus.i_readdatavalid); end
        nchk++; if (bus.d_readdatavalid !== 1'b0) begin nfail++; $display("FAIL sr_d_rdv: got %b want 0", bus.d_readdatavalid); end
        nchk++; if (bus.i_readdata !== 32'hDEAD_BEEF) begin nfail++; $display("FAIL sr_i_data: got %h want deadbeef", bus.i_readdata); end
        tick();
        bus.m_readdatavalid = 1'b0;
        #1;
        nchk++; if (bus.i_readdatavalid !== 1'b0) begin nfail++; $display("FAIL sr_after_i_rdv: got %b want 0", bus.i_readdatavalid); end
        nchk++; if (err !== 1'b0) begin nfail++; $display("FAIL sr_err: got %b want 0", err); end
    endtask

    task automatic test_collision();
        tick();
        bus.i_read       = 1'b1;
        bus.i_address    = 32'h0000_0200;
        bus.d_write      = 1'b1;
        bus.d_address    = 32'h8000_0000;
        bus.d_writedata  = 32'h1234_5678;
        bus.d_byteenable = 4'h3;
        #1;
        nchk++; if (bus.d_waitrequest !== 1'b1) begin nfail++; $display("FAIL col_idle_d_wr: got %b want 1", bus.d_waitrequest); end
        tick();
        #1;
        nchk++; if (bus.m_write !== 1'b1) begin nfail++; $display("FAIL col_d_m_write: got %b want 1", bus.m_write); end
        nchk++; if (bus.m_read !== 1'b0) begin nfail++; $display("FAIL col_d_m_read: got %b want 0", bus.m_read); end
        nchk++; if (bus.m_address !== 32'h8000_0000) begin nfail++; $display("FAIL col_d_addr: got %h want 80000000", bus.m_address); end
        nchk++; if (bus.m_writedata !== 32'h1234_5678) begin nfail++; $display("FAIL col_d_wdata: got %h want 12345678", bus.m_writedata); end
        nchk++; if (bus.m_byteenable !== 4'h3) begin nfail++; $display("FAIL col_d_be: got %h want 3", bus.m_byteenable); end
        nchk++; if (bus.d_waitrequest !== 1'b0) begin nfail++; $display("FAIL col_d_wr: got %b want 0", bus.d_waitrequest); end
        nchk++; if (bus.i_waitrequest !== 1'b1) begin nfail++; $display("FAIL col_i_stalled: got %b want 1", bus.i_waitrequest); end
        tick();
        bus.d_address    = 32'h8000_0004;
        bus.d_writedata  = 32'hCAFE_F00D;
        bus.d_byteenable = 4'hF;
        #1;
        nchk++; if ((bus.m_read | bus.m_write) !== 1'b0) begin nfail++; $display("FAIL col_gap_idle: got %b want 0", bus.m_read | bus.m_write); end
        tick();
        #1;
`ifdef KRV_AVM_ARB_RR_EN
        nchk++; if (bus.m_read !== 1'b1) begin nfail++; $display("FAIL col_rr_i_read: got %b want 1", bus.m_read); end
        nchk++; if (bus.m_address !== 32'h200) begin nfail++; $display("FAIL col_rr_i_addr: got %h want 00000200", bus.m_address); end
        tick();
        bus.i_read = 1'b0;
        #1;
        tick();
        #1;
        nchk++; if (bus.m_write !== 1'b1) begin nfail++; $display("FAIL col_rr_d_write: got %b want 1", bus.m_write); end
        nchk++; if (bus.m_writedata !== 32'hCAFE_F00D) begin nfail++; $display("FAIL col_rr_d_wdata: got %h want cafef00d", bus.m_writedata); end
`else
        nchk++; if (bus.m_write !== 1'b1) begin nfail++; $display("FAIL col_fx_d_write: got %b want 1", bus.m_write); end
        nchk++; if (bus.m_writedata !== 32'hCAFE_F00D) begin nfail++; $display("FAIL col_fx_d_wdata: got %h want cafef00d", bus.m_writedata); end
        nchk++; if (bus.i_waitrequest !== 1'b1) begin nfail++; $display("FAIL col_fx_i_stalled: got %b want 1", bus.i_waitrequest); end
        tick();
        bus.d_write = 1'b0;
        #1;
        tick();
        #1;
        nchk++; if (bus.m_read !== 1'b1) begin nfail++; $display("FAIL col_fx_i_read: got %b want 1", bus.m_read); end
        nchk++; if (bus.m_address !== 32'h200) begin nfail++; $display("FAIL col_fx_i_addr: got %h want 00000200", bus.m_address); end
`endif
        tick();
        bus.i_read  = 1'b0;
        bus.d_write = 1'b0;
        #1;
        tick();
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata      = 32'h0000_55AA;
        #1;
        nchk++; if (bus.i_readdatavalid !== 1'b1) begin nfail++; $display("FAIL col_i_rdv: got %b want 1", bus.i_readdatavalid); end
        tick();
        bus.m_readdatavalid = 1'b0;
    endtask

    task automatic test_wait_hold();
        tick();
        bus.d_write       = 1'b1;
        bus.d_address     = 32'h0000_0040;
        bus.d_writedata   = 32'hA5A5_A5A5;
        bus.d_byteenable  = 4'hC;
        bus.i_read        = 1'b1;
        bus.i_address     = 32'h0000_0300;
        bus.m_waitrequest = 1'b1;
        #1;
        tick();
        for (int k = 0; k < 6; k++) begin
            if (k == 5) bus.m_waitrequest = 1'b0;
            #1;
            nchk++; if (bus.m_write !== 1'b1) begin nfail++; $display("FAIL wh_m_write[%0d]: got %b want 1", k, bus.m_write); end
            nchk++; if (bus.m_address !== 32'h40) begin nfail++; $display("FAIL wh_addr[%0d]: got %h want 00000040", k, bus.m_address); end
            nchk++; if (bus.m_writedata !== 32'hA5A5_A5A5) begin nfail++; $display("FAIL wh_wdata[%0d]: got %h want a5a5a5a5", k, bus.m_writedata); end
            nchk++; if (bus.m_byteenable !== 4'hC) begin nfail++; $display("FAIL wh_be[%0d]: got %h want c", k, bus.m_byteenable); end
            nchk++; if (bus.i_waitrequest !== 1'b1) begin nfail++; $display("FAIL wh_i_wr[%0d]: got %b want 1", k, bus.i_waitrequest); end
            nchk++; if (bus.d_waitrequest !== (k != 5)) begin nfail++; $display("FAIL wh_d_wr[%0d]: got %b want %b", k, bus.d_waitrequest, k != 5); end
            tick();
        end
        bus.d_write = 1'b0;
        #1;
        nchk++; if (bus.m_write !== 1'b0) begin nfail++; $display("FAIL wh_idle_m_write: got %b want 0", bus.m_write); end
        tick();
        #1;
        nchk++; if (bus.m_read !== 1'b1) begin nfail++; $display("FAIL wh_i_read: got %b want 1", bus.m_read); end
        nchk++; if (bus.m_address !== 32'h300) begin nfail++; $display("FAIL wh_i_addr: got %h want 00000300", bus.m_address); end
        tick();
        bus.i_read = 1'b0;
        tick();
        bus.m_readdatavalid = 1'b1;
        #1;
        nchk++; if (bus.i_readdatavalid !== 1'b1) begin nfail++; $display("FAIL wh_i_rdv: got %b want 1", bus.i_readdatavalid); end
        tick();
        bus.m_readdatavalid = 1'b0;
    endtask

    task automatic test_full();
        tick();
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_1000;
        #1;
        for (int n = 0; n < 4; n++) begin
            tick();
            #1;
            nchk++; if (bus.m_read !== 1'b1) begin nfail++; $display("FAIL full_read[%0d]: got %b want 1", n, bus.m_read); end
            nchk++; if (bus.m_address !== (32'h1000 + 32'(4 * n))) begin nfail++; $display("FAIL full_addr[%0d]: got %h want %h", n, bus.m_address, 32'h1000 + 32'(4 * n)); end
            tick();
            bus.i_address = 32'h1000 + 32'(4 * (n + 1));
            #1;
        end
        bus.d_write      = 1'b1;
        bus.d_address    = 32'h0000_0050;
        bus.d_writedata  = 32'h0000_0011;
        bus.d_byteenable = 4'hF;
        #1;
        nchk++; if (bus.i_waitrequest !== 1'b1) begin nfail++; $display("FAIL full_i_wr: got %b want 1", bus.i_waitrequest); end
        tick();
        #1;
        nchk++; if (bus.m_write !== 1'b1) begin nfail++; $display("FAIL full_d_write: got %b want 1", bus.m_write); end
        nchk++; if (bus.m_read !== 1'b0) begin nfail++; $display("FAIL full_no_read: got %b want 0", bus.m_read); end
        tick();
        bus.d_write = 1'b0;
        #1;
        nchk++; if (bus.m_read !== 1'b0) begin nfail++; $display("FAIL full_blocked: got %b want 0", bus.m_read); end
        tick();
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata      = 32'h0;
        #1;
        nchk++; if (bus.i_readdatavalid !== 1'b1) begin nfail++; $display("FAIL full_pop_rdv: got %b want 1", bus.i_readdatavalid); end
        tick();
        bus.m_readdatavalid = 1'b0;
        #1;
        nchk++; if (bus.m_read !== 1'b0) begin nfail++; $display("FAIL full_pop_nogrant: got %b want 0", bus.m_read); end
        tick();
        #1;
        nchk++; if (bus.m_read !== 1'b1) begin nfail++; $display("FAIL full_resume_read: got %b want 1", bus.m_read); end
        nchk++; if (bus.m_address !== 32'h1010) begin nfail++; $display("FAIL full_resume_addr: got %h want 00001010", bus.m_address); end
        nchk++; if (bus.i_waitrequest !== 1'b0) begin nfail++; $display("FAIL full_resume_i_wr: got %b want 0", bus.i_waitrequest); end
        tick();
        bus.i_read          = 1'b0;
        bus.m_readdatavalid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            #1;
            nchk++; if (bus.i_readdatavalid !== 1'b1) begin nfail++; $display("FAIL full_drain[%0d]: got %b want 1", n, bus.i_readdatavalid); end
            tick();
        end
        bus.m_readdatavalid = 1'b0;
        #1;
        nchk++; if (err !== 1'b0) begin nfail++; $display("FAIL full_err: got %b want 0", err); end
    endtask

    task automatic test_interleave();
        tick();
        bus.d_read    = 1'b1;
        bus.d_address = 32'h0000_0060;
        #1;
        tick();
        #1;
        nchk++; if (bus.m_read !== 1'b1) begin nfail++; $display("FAIL il_d1_read: got %b want 1", bus.m_read); end
        nchk++; if (bus.m_address !== 32'h60) begin nfail++; $display("FAIL il_d1_addr: got %h want 00000060", bus.m_address); end
        nchk++; if (bus.d_waitrequest !== 1'b0) begin nfail++; $display("FAIL il_d1_wr: got %b want 0", bus.d_waitrequest); end
        tick();
        bus.d_read    = 1'b0;
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_0070;
        #1;
        tick();
        #1;
        nchk++; if (bus.m_address !== 32'h70) begin nfail++; $display("FAIL il_i_addr: got %h want 00000070", bus.m_address); end
        tick();
        bus.i_read    = 1'b0;
        bus.d_read    = 1'b1;
        bus.d_address = 32'h0000_0064;
        #1;
        tick();
        #1;
        nchk++; if (bus.m_address !== 32'h64) begin nfail++; $display("FAIL il_d2_addr: got %h want 00000064", bus.m_address); end
        tick();
        bus.d_read          = 1'b0;
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata      = 32'h1;
        #1;
        nchk++; if ({bus.d_readdatavalid, bus.i_readdatavalid} !== 2'b10) begin nfail++; $display("FAIL il_rsp1: got d,i=%b want 10", {bus.d_readdatavalid, bus.i_readdatavalid}); end
        nchk++; if (bus.d_readdata !== 32'h1) begin nfail++; $display("FAIL il_rsp1_data: got %h want 00000001", bus.d_readdata); end
        tick();
        bus.m_readdata = 32'h2;
        #1;
        nchk++; if ({bus.d_readdatavalid, bus.i_readdatavalid} !== 2'b01) begin nfail++; $display("FAIL il_rsp2: got d,i=%b want 01", {bus.d_readdatavalid, bus.i_readdatavalid}); end
        tick();
        bus.m_readdata = 32'h3;
        #1;
        nchk++; if ({bus.d_readdatavalid, bus.i_readdatavalid} !== 2'b10) begin nfail++; $display("FAIL il_rsp3: got d,i=%b want 10", {bus.d_readdatavalid, bus.i_readdatavalid}); end
        tick();
        bus.m_readdatavalid = 1'b0;
        #1;
    endtask

    task automatic test_unexpected_and_reset();
        tick();
        bus.m_readdatavalid = 1'b1;
        #1;
        nchk++; if ({bus.d_readdatavalid, bus.i_readdatavalid} !== 2'b00) begin nfail++; $display("FAIL ux_rdv: got d,i=%b want 00", {bus.d_readdatavalid, bus.i_readdatavalid}); end
        tick();
        bus.m_readdatavalid = 1'b0;
        #1;
        nchk++; if (err !== 1'b1) begin nfail++; $display("FAIL ux_err_set: got %b want 1", err); end
        tick();
        #1;
        nchk++; if (err !== 1'b1) begin nfail++; $display("FAIL ux_err_sticky: got %b want 1", err); end
        bus.d_write       = 1'b1;
        bus.d_address     = 32'h0000_0090;
        bus.d_writedata   = 32'h0000_0077;
        bus.d_byteenable  = 4'hF;
        bus.m_waitrequest = 1'b1;
        tick();
        #1;
        nchk++; if (bus.m_write !== 1'b1) begin nfail++; $display("FAIL ux_gnt_d: got %b want 1", bus.m_write); end
        tick();
        reset = 1'b1;
        #1;
        tick();
        #1;
        nchk++; if (bus.m_write !== 1'b0) begin nfail++; $display("FAIL ux_rst_m_write: got %b want 0", bus.m_write); end
        nchk++; if (bus.m_address !== 32'h0) begin nfail++; $display("FAIL ux_rst_addr: got %h want 0", bus.m_address); end
        nchk++; if (bus.m_writedata !== 32'h0) begin nfail++; $display("FAIL ux_rst_wdata: got %h want 0", bus.m_writedata); end
        nchk++; if (bus.m_byteenable !== 4'h0) begin nfail++; $display("FAIL ux_rst_be: got %h want 0", bus.m_byteenable); end
        nchk++; if (bus.d_waitrequest !== 1'b1) begin nfail++; $display("FAIL ux_rst_d_wr: got %b want 1", bus.d_waitrequest); end
        nchk++; if (err !== 1'b0) begin nfail++; $display("FAIL ux_rst_err: got %b want 0", err); end
        reset             = 1'b0;
        bus.d_write       = 1'b0;
        bus.m_waitrequest = 1'b0;
        tick();
    endtask

    initial begin
        nchk                = 0;
        nfail               = 0;
        reset               = 1'b1;
        bus.i_read          = 1'b0;
        bus.i_address       = '0;
        bus.d_read          = 1'b0;
        bus.d_write         = 1'b0;
        bus.d_address       = '0;
        bus.d_writedata     = '0;
        bus.d_byteenable    = '0;
        bus.m_waitrequest   = 1'b0;
        bus.m_readdata      = '0;
        bus.m_readdatavalid = 1'b0;

        test_reset();
        test_single_read();
        test_collision();
        test_wait_hold();
        test_full();
        test_interleave();
        test_unexpected_and_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
